// File: rtl/lcd_bus_if.sv
// Host-side LCD control strobes (register select, read/write, enable).
// The bidirectional data bus stays a plain top-level inout so its tristate driver is in one obvious place.
interface lcd_bus_if;
  logic lcd_rs;
  logic lcd_rw;
  logic lcd_e;

  modport master (output lcd_rs, output lcd_rw, output lcd_e);
  modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_e);
endinterface

// File: rtl/lcd_responder.sv
// Behavioural HD44780-style LCD controller responder: synchronised bus, busy timing,
// address counter, 128-byte DDRAM with clear-fill, and a registered debug read port.
module lcd_responder #(
  parameter int CMD_CYCLES   = 1850,
  parameter int CLEAR_CYCLES = 76500
) (
  input  logic       clk,
  input  logic       lcd_reset,
  lcd_bus_if.slave   bus,
  inout  wire  [7:0] lcd_data,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_char,
  output logic       overrun,
  output logic       mode_err
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CMD_LOAD = CNT_W'(CMD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_BUSY} state_t;
  typedef enum logic [3:0] {
    C_NONE, C_CLEAR, C_HOME, C_ENTRY, C_DISP, C_SHIFT, C_FUNC, C_CGRAM, C_DDRAM
  } cmd_t;

  state_t           r_state, w_next;
  cmd_t             w_cmd;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_fill_idx;
  logic [6:0]       r_ac;
  logic             r_id, r_disp_on, r_mode_err, r_overrun;
  logic [7:0]       r_dbg_char;
  logic [7:0]       r_ddram [128];

  logic       r_e_s1, r_e_s2, r_e_s3;
  logic       r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
  logic [7:0] r_d_s1, r_d_s2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (lcd_reset) begin
      r_e_s1  <= 1'b0;
      r_e_s2  <= 1'b0;
      r_e_s3  <= 1'b0;
      r_rs_s1 <= 1'b0;
      r_rs_s2 <= 1'b0;
      r_rw_s1 <= 1'b0;
      r_rw_s2 <= 1'b0;
      r_d_s1  <= 8'h00;
      r_d_s2  <= 8'h00;
    end else begin
      r_e_s1  <= bus.lcd_e;
      r_e_s2  <= r_e_s1;
      r_e_s3  <= r_e_s2;
      r_rs_s1 <= bus.lcd_rs;
      r_rs_s2 <= r_rs_s1;
      r_rw_s1 <= bus.lcd_rw;
      r_rw_s2 <= r_rw_s1;
      r_d_s1  <= lcd_data;
      r_d_s2  <= r_d_s1;
    end
  end

  logic       w_e_fall, w_idle, w_wr, w_wr_ok, w_inst_wr, w_data_wr, w_data_rd;
  logic       w_start_fill, w_start_long;
  logic [6:0] w_ac_step;

  assign w_e_fall     = r_e_s3 & ~r_e_s2;
  assign w_idle       = (r_state == S_IDLE);
  assign w_wr         = w_e_fall & ~r_rw_s2;
  assign w_wr_ok      = w_wr & w_idle;
  assign w_inst_wr    = w_wr_ok & ~r_rs_s2;
  assign w_data_wr    = w_wr_ok & r_rs_s2;
  assign w_data_rd    = w_e_fall & r_rw_s2 & r_rs_s2 & w_idle;
  assign w_ac_step    = r_id ? r_ac + 7'd1 : r_ac - 7'd1;
  assign w_start_fill = w_inst_wr && (w_cmd == C_CLEAR);
  assign w_start_long = w_inst_wr && (w_cmd == C_HOME);

  // Instruction class is chosen by the highest set bit of the command byte.
  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    w_cmd = C_NONE;
    if      (r_d_s2[7]) w_cmd = C_DDRAM;
    else if (r_d_s2[6]) w_cmd = C_CGRAM;
    else if (r_d_s2[5]) w_cmd = C_FUNC;
    else if (r_d_s2[4]) w_cmd = C_SHIFT;
    else if (r_d_s2[3]) w_cmd = C_DISP;
    else if (r_d_s2[2]) w_cmd = C_ENTRY;
    else if (r_d_s2[1]) w_cmd = C_HOME;
    else if (r_d_s2[0]) w_cmd = C_CLEAR;
  end

  always_ff @(posedge clk) begin
    if (lcd_reset) r_state <= S_FILL;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_fill) w_next = S_FILL;
        else if (w_wr_ok) w_next = S_BUSY;
      end
      S_FILL: begin
        if (r_fill_idx == 7'd127) w_next = (r_cnt == '0) ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        if (r_cnt == '0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Busy down-counter is loaded on the commit edge and runs through FILL and BUSY alike.
  always_ff @(posedge clk) begin
    if (lcd_reset) begin
      r_cnt      <= CLR_LOAD;
      r_fill_idx <= 7'd0;
    end else begin
      if (w_start_fill || w_start_long) r_cnt <= CLR_LOAD;
      else if (w_wr_ok)                 r_cnt <= CMD_LOAD;
      else if (!w_idle && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
      if (r_state == S_FILL) r_fill_idx <= r_fill_idx + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (lcd_reset) begin
      r_ac       <= 7'd0;
      r_id       <= 1'b1;
      r_disp_on  <= 1'b0;
      r_mode_err <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= w_wr & ~w_idle;
      if (w_data_wr || w_data_rd) r_ac <= w_ac_step;
      if (w_inst_wr) begin
        case (w_cmd)
          C_CLEAR: begin
            r_ac <= 7'd0;
            r_id <= 1'b1;
          end
          C_HOME:  r_ac      <= 7'd0;
          C_ENTRY: r_id      <= r_d_s2[1];
          C_DISP:  r_disp_on <= r_d_s2[2];
          C_SHIFT: if (!r_d_s2[3]) r_ac <= r_d_s2[2] ? r_ac + 7'd1 : r_ac - 7'd1;
          C_FUNC:  if (!r_d_s2[4]) r_mode_err <= 1'b1;
          C_DDRAM: r_ac      <= r_d_s2[6:0];
          default: ;
        endcase
      end
    end
  end

  // NOTE: DDRAM is deliberately not reset; the FILL sequence entered on reset initialises it.
  always_ff @(posedge clk) begin
    if (r_state == S_FILL)  r_ddram[r_fill_idx] <= 8'h20;
    else if (w_data_wr)     r_ddram[r_ac]       <= r_d_s2;
    r_dbg_char <= r_ddram[dbg_addr];
  end

  logic       w_rd_en;
  logic [7:0] w_rd_data;

  assign w_rd_en   = r_e_s2 & r_rw_s2;
  assign w_rd_data = r_rs_s2 ? r_ddram[r_ac] : {busy, r_ac};
  assign lcd_data  = w_rd_en ? w_rd_data : 8'bzzzz_zzzz;

  assign ac       = r_ac;
  assign disp_on  = r_disp_on;
  assign dbg_char = r_dbg_char;
  assign overrun  = r_overrun;
  assign mode_err = r_mode_err;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: bus writes/reads through the pin-level protocol,
// busy timing, AC wrap, overrun, clear-fill and reset recovery.
module tb_lcd_responder;

  localparam int CMD   = 40;
  localparam int CLEAR = 300;

  logic       clk = 1'b0;
  logic       lcd_reset;
  logic [6:0] dbg_addr;
  logic       busy, disp_on, overrun, mode_err;
  logic [6:0] ac;
  logic [7:0] dbg_char;
  wire  [7:0] lcd_data;
  logic [7:0] tb_data;
  logic       tb_drive;

  int n_checks = 0;
  int n_errors = 0;
  int run_len  = 0;
  int busy_len = 0;
  int ovr_cnt  = 0;

  lcd_bus_if bus ();

  lcd_responder #(.CMD_CYCLES(CMD), .CLEAR_CYCLES(CLEAR)) dut (
    .clk       (clk),
    .lcd_reset (lcd_reset),
    .bus       (bus.slave),
    .lcd_data  (lcd_data),
    .busy      (busy),
    .ac        (ac),
    .disp_on   (disp_on),
    .dbg_addr  (dbg_addr),
    .dbg_char  (dbg_char),
    .overrun   (overrun),
    .mode_err  (mode_err)
  );

  // Weak pull-ups make a released bus read back as 0xFF.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (lcd_data[i]);
  end
  assign lcd_data = tb_drive ? tb_data : 8'bzzzz_zzzz;

  always #10 clk = ~clk;

  // Length of the most recent busy run and count of overrun pulses.
  always @(negedge clk) begin
    if (lcd_reset) run_len = 0;
    else if (busy) run_len = run_len + 1;
    else if (run_len != 0) begin
      busy_len = run_len;
      run_len  = 0;
    end
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic lcd_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    bus.lcd_rs = rs;
    bus.lcd_rw = 1'b0;
    tb_data    = d;
    tb_drive   = 1'b1;
    repeat (2) @(negedge clk);
    bus.lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    bus.lcd_e = 1'b0;
    repeat (5) @(negedge clk);
    tb_drive   = 1'b0;
    bus.lcd_rs = 1'b0;
  endtask

  task automatic lcd_read(input logic rs, output logic [7:0] v, output logic [7:0] v_rel);
    @(negedge clk);
    tb_drive   = 1'b0;
    bus.lcd_rs = rs;
    bus.lcd_rw = 1'b1;
    repeat (2) @(negedge clk);
    bus.lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    v = lcd_data;
    bus.lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    v_rel = lcd_data;
    bus.lcd_rw = 1'b0;
    bus.lcd_rs = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100000) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    lcd_write(rs, d);
    wait_idle();
  endtask

  task automatic dbg_read(input logic [6:0] a, output logic [7:0] v);
    @(negedge clk);
    dbg_addr = a;
    @(negedge clk);
    v = dbg_char;
  endtask

  logic [7:0] v, v_rel;
  int         ovr_base;
  int         polls;

  initial begin
    lcd_reset  = 1'b1;
    bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b0;
    bus.lcd_e  = 1'b0;
    tb_data    = 8'h00;
    tb_drive   = 1'b0;
    dbg_addr   = 7'd0;
    repeat (4) @(negedge clk);
    check("rst_busy", busy, 1'b1);
    check("rst_ac", ac, 7'd0);
    check("rst_disp_on", disp_on, 1'b0);
    check("rst_mode_err", mode_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_bus_hiz", lcd_data, 8'hFF);
    @(posedge clk);
    #1 lcd_reset = 1'b0;
    wait_idle();
    check("rst_busy_len", busy_len, CLEAR);
    dbg_read(7'd3, v);
    check("rst_fill_3", v, 8'h20);

    // Data write at AC=0.
    send(1'b1, 8'h41);
    check("wr41_busy_len", busy_len, CMD);
    check("wr41_ac", ac, 7'd1);
    dbg_read(7'd0, v);
    check("wr41_ddram0", v, 8'h41);

    // Increment wrap 127 -> 0.
    send(1'b0, 8'hFF);
    check("setaddr7f_ac", ac, 7'h7F);
    send(1'b1, 8'h42);
    check("wrap_inc_ac", ac, 7'd0);
    dbg_read(7'd127, v);
    check("wrap_inc_ddram127", v, 8'h42);

    // Decrement wrap 0 -> 127.
    send(1'b0, 8'h04);
    send(1'b0, 8'h80);
    send(1'b1, 8'h43);
    check("wrap_dec_ac", ac, 7'h7F);
    dbg_read(7'd0, v);
    check("wrap_dec_ddram0", v, 8'h43);

    // Overrun: second write lands while the first is still busy.
    send(1'b0, 8'h06);
    send(1'b0, 8'h90);
    ovr_base = ovr_cnt;
    lcd_write(1'b1, 8'h44);
    repeat (5) @(negedge clk);
    lcd_write(1'b1, 8'h45);
    wait_idle();
    check("ovr_pulses", ovr_cnt - ovr_base, 1);
    dbg_read(7'h10, v);
    check("ovr_ddram10", v, 8'h44);
    dbg_read(7'h11, v);
    check("ovr_ddram11", v, 8'h20);
    check("ovr_ac", ac, 7'h11);

    // Cursor shift and display control.
    send(1'b0, 8'h14);
    check("shift_right_ac", ac, 7'h12);
    send(1'b0, 8'h10);
    check("shift_left_ac", ac, 7'h11);
    send(1'b0, 8'h18);
    check("disp_shift_ac", ac, 7'h11);
    send(1'b0, 8'h0C);
    check("disp_on_set", disp_on, 1'b1);

    // Clear display with busy polling.
    send(1'b0, 8'h80);
    send(1'b1, 8'h31);
    send(1'b1, 8'h32);
    send(1'b1, 8'h33);
    send(1'b1, 8'h34);
    dbg_read(7'd2, v);
    check("pre_clear_ddram2", v, 8'h33);
    send(1'b0, 8'h04);
    lcd_write(1'b0, 8'h01);
    polls = 0;
    lcd_read(1'b0, v, v_rel);
    while (v[7] && polls < 100) begin
      check("clear_poll", v, 8'h80);
      lcd_read(1'b0, v, v_rel);
      polls++;
    end
    check("clear_poll_done", v, 8'h00);
    check("clear_busy_len", busy_len, CLEAR);
    check("clear_ac", ac, 7'd0);
    for (int a = 0; a < 4; a++) begin
      dbg_read(7'(a), v);
      check("clear_fill", v, 8'h20);
    end
    dbg_read(7'd127, v);
    check("clear_fill_127", v, 8'h20);
    send(1'b1, 8'h77);
    check("clear_id_restored", ac, 7'd1);

    // Data read while busy returns DDRAM[AC] without stepping AC.
    send(1'b0, 8'hA0);
    lcd_write(1'b1, 8'h66);
    lcd_read(1'b1, v, v_rel);
    check("busy_read_data", v, 8'h20);
    check("busy_read_ac", ac, 7'h21);
    check("busy_read_still_busy", busy, 1'b1);
    wait_idle();
    check("busy_read_ac_after", ac, 7'h21);
    dbg_read(7'h20, v);
    check("busy_read_ddram20", v, 8'h66);
    lcd_read(1'b0, v, v_rel);
    check("status_read", v, 8'h21);

    // Function set with DL=0 and data read at address 5.
    send(1'b0, 8'h28);
    check("mode_err_set", mode_err, 1'b1);
    send(1'b0, 8'h85);
    send(1'b1, 8'h55);
    check("wr55_ac", ac, 7'd6);
    send(1'b0, 8'h85);
    lcd_read(1'b1, v, v_rel);
    check("data_read", v, 8'h55);
    check("data_read_hiz", v_rel, 8'hFF);
    wait_idle();
    check("data_read_ac", ac, 7'd6);
    send(1'b0, 8'h30);
    check("mode_err_sticky", mode_err, 1'b1);

    // Return home.
    send(1'b0, 8'h02);
    check("home_ac", ac, 7'd0);
    check("home_busy_len", busy_len, CLEAR);

    // Reset mid-busy restarts the fill sequence.
    send(1'b0, 8'h8A);
    lcd_write(1'b1, 8'h99);
    @(negedge clk);
    lcd_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_ac", ac, 7'd0);
    check("rst2_disp_on", disp_on, 1'b0);
    check("rst2_mode_err", mode_err, 1'b0);
    @(posedge clk);
    #1 lcd_reset = 1'b0;
    wait_idle();
    check("rst2_busy_len", busy_len, CLEAR);
    dbg_read(7'h0A, v);
    check("rst2_ddram0a", v, 8'h20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
